// File: rtl/fetch_if.sv
// Fetch-stage bus: redirect and stall controls, instruction memory port, IR toward decode.
// Also carries the fetch mode so checkers can observe it.
interface fetch_if #(
    parameter int WIDTH = 16
);
    // Handshake: decode takes IR on any rising edge where IR_valid=1 and stall=0.
    // While stall=1, IR/IR_pc/IR_valid hold. PC_load=1 wins over stall.
    logic             PC_load;
    logic [WIDTH-1:0] target;
    logic             stall;
    logic [WIDTH-1:0] imem_addr;
    logic [WIDTH-1:0] imem_rdata;
    logic [WIDTH-1:0] IR;
    logic [WIDTH-1:0] IR_pc;
    logic             IR_valid;
    logic [1:0]       dbg_state;

    modport slave (
        input  PC_load,
        input  target,
        input  stall,
        input  imem_rdata,
        output imem_addr,
        output IR,
        output IR_pc,
        output IR_valid,
        output dbg_state
    );

    modport master (
        output PC_load,
        output target,
        output stall,
        output imem_rdata,
        input  imem_addr,
        input  IR,
        input  IR_pc,
        input  IR_valid,
        input  dbg_state
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage for a one-cycle-latency synchronous instruction memory.
// A one-entry hold buffer keeps the in-flight word safe across decode stalls.
module fetch_stage #(
    parameter int               WIDTH    = 16,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input logic  clk,
    input logic  rst,
    fetch_if.slave bus
);
    localparam logic [1:0] ST_EMPTY  = 2'd0;
    localparam logic [1:0] ST_STREAM = 2'd1;
    localparam logic [1:0] ST_HELD   = 2'd2;

    logic [WIDTH-1:0] pc_q,        pc_d;
    logic [WIDTH-1:0] fetch_pc_q,  fetch_pc_d;
    logic             inflight_q,  inflight_d;
    logic [WIDTH-1:0] hold_data_q, hold_data_d;
    logic [WIDTH-1:0] hold_addr_q, hold_addr_d;
    logic             hold_valid_q, hold_valid_d;
    logic [WIDTH-1:0] ir_q,        ir_d;
    logic [WIDTH-1:0] ir_pc_q,     ir_pc_d;
    logic             ir_valid_q,  ir_valid_d;

    logic [WIDTH-1:0] next_ir;
    logic [WIDTH-1:0] next_ir_pc;
    logic [1:0]       state;

    // The held word is older than anything on imem_rdata, so it drains first.
    always_comb begin
        if (hold_valid_q) begin
            next_ir    = hold_data_q;
            next_ir_pc = hold_addr_q;
        end else begin
            next_ir    = bus.imem_rdata;
            next_ir_pc = fetch_pc_q;
        end
    end

    always_comb begin
        pc_d         = pc_q;
        fetch_pc_d   = fetch_pc_q;
        inflight_d   = inflight_q;
        hold_data_d  = hold_data_q;
        hold_addr_d  = hold_addr_q;
        hold_valid_d = hold_valid_q;
        ir_d         = ir_q;
        ir_pc_d      = ir_pc_q;
        ir_valid_d   = ir_valid_q;

        if (bus.PC_load) begin
            pc_d         = bus.target;
            inflight_d   = 1'b0;
            hold_valid_d = 1'b0;
            ir_valid_d   = 1'b0;
        end else if (!bus.stall) begin
            pc_d         = pc_q + 1'b1;
            fetch_pc_d   = pc_q;
            inflight_d   = 1'b1;
            ir_d         = next_ir;
            ir_pc_d      = next_ir_pc;
            ir_valid_d   = hold_valid_q | inflight_q;
            hold_valid_d = 1'b0;
        end else if (inflight_q && !hold_valid_q) begin
            // Memory does not hold its output, so park the returning word now.
            hold_data_d  = bus.imem_rdata;
            hold_addr_d  = fetch_pc_q;
            hold_valid_d = 1'b1;
            inflight_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q         <= RESET_PC;
            fetch_pc_q   <= '0;
            inflight_q   <= 1'b0;
            hold_data_q  <= '0;
            hold_addr_q  <= '0;
            hold_valid_q <= 1'b0;
            ir_q         <= '0;
            ir_pc_q      <= '0;
            ir_valid_q   <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            fetch_pc_q   <= fetch_pc_d;
            inflight_q   <= inflight_d;
            hold_data_q  <= hold_data_d;
            hold_addr_q  <= hold_addr_d;
            hold_valid_q <= hold_valid_d;
            ir_q         <= ir_d;
            ir_pc_q      <= ir_pc_d;
            ir_valid_q   <= ir_valid_d;
        end
    end

    // inflight and hold_valid are never both set, so the mode is a pure decode.
    always_comb begin
        if (hold_valid_q) begin
            state = ST_HELD;
        end else if (inflight_q) begin
            state = ST_STREAM;
        end else begin
            state = ST_EMPTY;
        end
    end

    assign bus.imem_addr = pc_q;
    assign bus.IR        = ir_q;
    assign bus.IR_pc     = ir_pc_q;
    assign bus.IR_valid  = ir_valid_q;
    assign bus.dbg_state = state;
endmodule
